crc32_fcs_checker_64: RTL
=========================

// Module: crc32_fcs_checker_64
// PURPOSE
//  Receive-side counterpart of the 64-bit CRC32 generator. Accepts 64-bit AXI4-Stream frames that end in a 4-byte Ethernet FCS.
//  The FCS is sent LSB-first, i.e. byte0 = (~crc)[7:0].
//  Verifies the FCS by residue check, strips the FCS bytes and forwards the payload.
//  Flags a CRC error on the payload's tlast beat and keeps good/bad/runt frame counters.
// PARAMETERS
//  CRC_INIT     32'hFFFFFFFF  seed loaded at every frame start
//  CRC_RESIDUE  32'hDEBB20E3  required un-inverted LSB-first CRC state after all bytes, FCS included
//  CNT_W        32            width of each statistics counter
// PORTS
//  clk            in   1      single clock domain
//  rst            in   1      synchronous reset, active-high
//  s_axis_tdata   in   64     frame bytes; byte0 = [7:0] is first on the wire
//  s_axis_tkeep   in   8      contiguous from bit0; 8'hFF on every non-last beat (input contract)
//  s_axis_tvalid  in   1      input beat valid
//  s_axis_tlast   in   1      last beat of frame, FCS included
//  s_axis_tready  out  1      input ready
//  m_axis_tdata   out  64     payload data, FCS removed
//  m_axis_tkeep   out  8      payload byte enables, contiguous
//  m_axis_tvalid  out  1      output beat valid
//  m_axis_tlast   out  1      last payload beat
//  m_axis_tuser   out  1      crc_err; meaningful only on the tlast beat, 0 elsewhere
//  m_axis_tready  in   1      downstream ready
//  check_enable   in   1      sampled on each frame's first beat; 0 forces crc_err=0
//  good_cnt       out  CNT_W  frames with correct FCS, or any non-runt frame with check disabled
//  bad_cnt        out  CNT_W  frames with FCS mismatch
//  runt_cnt       out  CNT_W  frames of 4 bytes or fewer; these are dropped
// BEHAVIOUR
//  - Reset: m_axis_tvalid/tlast/tuser=0, tdata=0, tkeep=0, all counters=0, FSM=EMPTY, crc=CRC_INIT.
//    Reset mid-frame discards the partial frame with no count; the next accepted beat is a frame start.
//  - Handshake: s_axis_tready = (!m_axis_tvalid || m_axis_tready) && state!=TAIL.
//    Output regs update only when (!m_axis_tvalid || m_axis_tready). AXIS-compliant: no valid drop without ready.
//  - CRC: running state is updated per accepted beat with all tkeep bytes, FCS included.
//    On a first beat, the seed is CRC_INIT. crc_err = check_en_f && (final_state != CRC_RESIDUE).
//  - One-beat hold register delays output: a non-last beat is emitted when the next beat of its frame is accepted.
//  - Last beat accepted, k = popcount(tkeep):
//      k>4, hold valid: emit hold as non-last, then tail (keep = k-4 low bytes, tlast, crc_err).
//        State goes to TAIL, tready=0 until tail is emitted.
//      k>4, no hold (single beat): emit one beat, keep k-4, tlast, crc_err. No TAIL.
//      k<=4, hold valid: emit hold with tlast, keep = 8'hFF >> (4-k), crc_err. The last input beat is discarded.
//      k<=4, no hold: runt; nothing emitted, runt_cnt+1, neither good nor bad counted.
//  - FSM:
//      EMPTY -first non-last beat-> HOLD
//      HOLD  -non-last-> HOLD (emit old hold)
//      HOLD  -last k<=4-> EMPTY
//      HOLD  -last k>4-> TAIL
//      TAIL  -tail emitted-> EMPTY
//  - Back-to-back frames without gap are required at full rate, except the 1 stall cycle per TAIL.
//  - Counters increment in the cycle the input last beat is accepted; they wrap modulo 2^CNT_W.
//  - Latency: first output valid 1 cycle after the 2nd beat of a frame is accepted, or after the last beat for single-beat frames.
// STRUCTURE
//  - Shared pkg crc32_pkg: CRC32_POLY_LSB=32'hEDB88320, CRC32_RESIDUE, fsm state typedef {EMPTY,HOLD,TAIL},
//    function keep_popcount8, function keep_from_count.
//  - One sub-module crc32_d64_update: combinational (crc_in, data[63:0], keep[7:0]) -> crc_out, byte0 first.
//    The same function is reused by the generator.
// TESTING
//  1. "123456789" + FCS 26 39 F4 CB (13 B: FF beat, then keep 1F) -> beat0 keep FF, beat1 keep 01 ('9') tlast, tuser=0, good_cnt=1.
//  2. Same frame, byte2 bit0 flipped -> identical framing, tuser=1 on tlast, bad_cnt=1, good_cnt=0.
//  3. 66-byte frame, valid FCS (8 FF beats + keep 03) -> 8 output beats, last keep 3F, tuser=0, no tready stall.
//  4. Single-beat 3-byte frame -> no output, runt_cnt=1.
//     Then 8-byte single beat (4 B + valid FCS) -> one beat keep 0F, tlast, tuser=0.
//  5. 200 random frames (5..1518 B, 10% corrupted), back-to-back, m_axis_tready 50% random ->
//     payload stream byte-exact vs model, good+bad=200, tuser matches corruption, no dup/loss.
//  6. rst high 1 cycle mid-frame (beat 3 of 8) -> next cycle m_axis_tvalid=0, counters=0.
//     Following clean frame checks good. check_enable=0 with bad FCS -> tuser=0, good_cnt+1.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared CRC32 (Ethernet, LSB-first) constants, checker FSM state type and tkeep helpers.
// Used by both the 64-bit FCS generator and checker.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_LSB = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    TAIL  = 2'd2
  } fcs_state_t;

  function automatic logic [3:0] keep_popcount8(input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

  // Contiguous low-byte enable mask with n bytes set (n = 0..8).
  function automatic logic [7:0] keep_from_count(input logic [3:0] n);
    logic [7:0] k;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k[i] = (4'(i) < n);
    end
    return k;
  endfunction

endpackage

// File: rtl/crc32_d64_update.sv
// Combinational CRC32 update over up to 8 bytes of a 64-bit beat, byte0 ([7:0]) first.
// Bytes whose keep bit is clear leave the CRC untouched.
module crc32_d64_update
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [7:0]  keep,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (keep[b]) begin
        c = c ^ {24'h000000, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) begin
          c = c[0] ? ((c >> 1) ^ CRC32_POLY_LSB) : (c >> 1);
        end
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc32_fcs_checker_64.sv
// 64-bit AXI4-Stream Ethernet FCS checker: residue-checks each frame, strips the 4 FCS
// bytes, flags crc_err in tuser on the payload's last beat and counts good/bad/runt frames.
module crc32_fcs_checker_64
  import crc32_pkg::*;
#(
  parameter logic [31:0] CRC_INIT    = CRC32_INIT,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             m_axis_tready,
  input  logic             check_enable,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] runt_cnt,
  output fcs_state_t       dbg_state
);

  // Handshake: a beat transfers on an edge where valid && ready. The output register may only
  // be reloaded when it is empty or being consumed (out_adv); a presented beat never changes
  // or drops before it is accepted. Input is refused while the tail beat waits in TAIL.

  fcs_state_t  state_q, state_d;
  logic [31:0] crc_q, crc_seed, crc_next;
  logic        chk_en_q, chk_en;
  logic [63:0] hold_q;
  logic [63:0] tail_data_q;
  logic [7:0]  tail_keep_q;
  logic        tail_err_q;

  logic        out_adv, acc, frame_start, big_last, crc_err;
  logic [3:0]  k;

  logic        emit, emit_last, emit_user, load_tail;
  logic [63:0] emit_data;
  logic [7:0]  emit_keep;
  logic        inc_good, inc_bad, inc_runt;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign out_adv       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = out_adv && (state_q != TAIL);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign frame_start   = (state_q == EMPTY);
  assign crc_seed      = frame_start ? CRC_INIT : crc_q;
  assign chk_en        = frame_start ? check_enable : chk_en_q;
  assign k             = keep_popcount8(s_axis_tkeep);
  assign big_last      = (k > 4'd4);
  assign crc_err       = chk_en && (crc_next != CRC_RESIDUE);
  assign dbg_state     = state_q;

  crc32_d64_update u_crc (
    .crc_in  (crc_seed),
    .data    (s_axis_tdata),
    .keep    (s_axis_tkeep),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (acc && !s_axis_tlast) state_d = HOLD;
      HOLD:    if (acc && s_axis_tlast)  state_d = big_last ? TAIL : EMPTY;
      TAIL:    if (out_adv)              state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    emit_data = hold_q;
    emit_keep = 8'hFF;
    emit_last = 1'b0;
    emit_user = 1'b0;
    load_tail = 1'b0;
    inc_good  = 1'b0;
    inc_bad   = 1'b0;
    inc_runt  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc && s_axis_tlast) begin
          if (big_last) begin
            emit      = 1'b1;
            emit_data = s_axis_tdata;
            emit_keep = keep_from_count(k - 4'd4);
            emit_last = 1'b1;
            emit_user = crc_err;
            inc_good  = !crc_err;
            inc_bad   = crc_err;
          end else begin
            inc_runt  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (acc) begin
          emit = 1'b1;
          if (s_axis_tlast) begin
            inc_good = !crc_err;
            inc_bad  = crc_err;
            if (big_last) begin
              load_tail = 1'b1;
            end else begin
              // Whole FCS (and nothing else) sits in the last input beat or straddles into hold.
              emit_keep = 8'hFF >> (4'd4 - k);
              emit_last = 1'b1;
              emit_user = crc_err;
            end
          end
        end
      end
      TAIL: begin
        if (out_adv) begin
          emit      = 1'b1;
          emit_data = tail_data_q;
          emit_keep = tail_keep_q;
          emit_last = 1'b1;
          emit_user = tail_err_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q         <= CRC_INIT;
      chk_en_q      <= 1'b0;
      hold_q        <= '0;
      tail_data_q   <= '0;
      tail_keep_q   <= '0;
      tail_err_q    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      runt_cnt      <= '0;
    end else begin
      if (acc) begin
        crc_q    <= crc_next;
        chk_en_q <= chk_en;
        if (!s_axis_tlast) hold_q <= s_axis_tdata;
      end
      if (load_tail) begin
        tail_data_q <= s_axis_tdata;
        tail_keep_q <= keep_from_count(k - 4'd4);
        tail_err_q  <= crc_err;
      end
      if (out_adv) begin
        m_axis_tvalid <= emit;
        if (emit) begin
          m_axis_tdata <= emit_data;
          m_axis_tkeep <= emit_keep;
          m_axis_tlast <= emit_last;
          m_axis_tuser <= emit_user;
        end
      end
      if (inc_good) good_cnt <= good_cnt + CNT_ONE;
      if (inc_bad)  bad_cnt  <= bad_cnt + CNT_ONE;
      if (inc_runt) runt_cnt <= runt_cnt + CNT_ONE;
    end
  end

endmodule
